// File: rtl/ex_mem_pkg.sv
// Shared defines for the EX/MEM pipeline register slice: bus widths,
// NOP/bubble constants and the stall encoding reused by id_ex and mem_wb.
package ex_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;
    localparam int DBL_W      = 2 * DATA_W;
    localparam int BUB_W_DEF  = 16;

    typedef logic [DATA_W-1:0]     reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [DBL_W-1:0]      double_reg_bus_t;

    localparam reg_bus_t      ZeroWord     = '0;
    localparam reg_addr_bus_t NOPRegAddr   = '0;
    localparam logic          WriteEnable  = 1'b1;
    localparam logic          WriteDisable = 1'b0;
    localparam logic          RstEnable    = 1'b1;

    // Stall encoding, indexed as {stall_mem, stall_ex}. Stalls are monotone:
    // a stalled later stage implies every earlier stage is stalled too.
    localparam logic [1:0] STALL_NONE    = 2'b00;
    localparam logic [1:0] STALL_BUBBLE  = 2'b01;  // EX stalled, MEM free
    localparam logic [1:0] STALL_ILLEGAL = 2'b10;  // MEM stalled, EX running
    localparam logic [1:0] STALL_HOLD    = 2'b11;  // both stalled

    // Everything that travels from EX to MEM for the write-back path.
    typedef struct packed {
        reg_bus_t      wdata;
        reg_addr_bus_t waddr;
        logic          wr_en;
        reg_bus_t      hi;
        reg_bus_t      lo;
        logic          whilo;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{
        wdata: ZeroWord, waddr: NOPRegAddr, wr_en: WriteDisable,
        hi: ZeroWord, lo: ZeroWord, whilo: WriteDisable
    };

endpackage

// File: rtl/ex_mem_if.sv
// EX <-> MEM bus: EX-side results in, MEM-side registered copies out,
// plus the MADD/MSUB accumulator loop back to EX.
interface ex_mem_if;
    import ex_mem_pkg::*;

    reg_bus_t        ex_wdata;
    reg_addr_bus_t   ex_waddr;
    logic            ex_wr_en;
    reg_bus_t        ex_hi;
    reg_bus_t        ex_lo;
    logic            ex_whilo;
    double_reg_bus_t hilo_temp_i;
    logic [CNT_W-1:0] cnt_i;

    reg_bus_t        mem_wdata;
    reg_addr_bus_t   mem_waddr;
    logic            mem_wr_en;
    reg_bus_t        mem_hi;
    reg_bus_t        mem_lo;
    logic            mem_whilo;
    double_reg_bus_t hilo_temp_o;
    logic [CNT_W-1:0] cnt_o;

    // EX stage side: produces results, consumes the accumulator feedback.
    modport master (
        output ex_wdata, ex_waddr, ex_wr_en, ex_hi, ex_lo, ex_whilo,
               hilo_temp_i, cnt_i,
        input  mem_wdata, mem_waddr, mem_wr_en, mem_hi, mem_lo, mem_whilo,
               hilo_temp_o, cnt_o
    );

    // Pipeline register side.
    modport slave (
        input  ex_wdata, ex_waddr, ex_wr_en, ex_hi, ex_lo, ex_whilo,
               hilo_temp_i, cnt_i,
        output mem_wdata, mem_waddr, mem_wr_en, mem_hi, mem_lo, mem_whilo,
               hilo_temp_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register. Priority: rst > flush > stall_mem > stall_ex.
// During an EX-only stall MEM gets a bubble while the partial MADD/MSUB
// product is looped back so EX can continue its multi-cycle op.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int BUB_W = BUB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_ex,
    input  logic             stall_mem,
    input  logic             flush,
    ex_mem_if.slave          bus,
    output logic [BUB_W-1:0] bubble_cnt
);

    stage_t           stage_d,  stage_q;
    double_reg_bus_t  hilo_temp_d, hilo_temp_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [BUB_W-1:0] bubble_d, bubble_q;
    logic             bubble_ins;
    stage_t           ex_stage;
    logic [1:0]       stall_code;

    assign ex_stage = '{
        wdata: bus.ex_wdata, waddr: bus.ex_waddr, wr_en: bus.ex_wr_en,
        hi: bus.ex_hi, lo: bus.ex_lo, whilo: bus.ex_whilo
    };
    assign stall_code = {stall_mem, stall_ex};

    // Next-state selection for the stage payload and accumulator loop.
    always_comb begin
        stage_d     = stage_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        bubble_ins  = 1'b0;
        if (flush) begin
            stage_d     = STAGE_BUBBLE;
            hilo_temp_d = '0;
            cnt_d       = '0;
            bubble_ins  = 1'b1;
        end else begin
            case (stall_code)
                STALL_NONE: begin
                    stage_d     = ex_stage;
                    hilo_temp_d = '0;
                    cnt_d       = '0;
                end
                STALL_BUBBLE: begin
                    stage_d     = STAGE_BUBBLE;
                    hilo_temp_d = bus.hilo_temp_i;
                    cnt_d       = bus.cnt_i;
                    bubble_ins  = 1'b1;
                end
                // STALL_HOLD and the (controller-forbidden) STALL_ILLEGAL
                // both freeze everything.
                default: ;
            endcase
        end
    end

    // Debug bubble counter, sticks at all-ones instead of wrapping.
    always_comb begin
        bubble_d = bubble_q;
        if (bubble_ins && (bubble_q != {BUB_W{1'b1}}))
            bubble_d = bubble_q + BUB_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stage_q     <= STAGE_BUBBLE;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
            bubble_q    <= '0;
        end else begin
            stage_q     <= stage_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
            bubble_q    <= bubble_d;
        end
    end

    assign bus.mem_wdata   = stage_q.wdata;
    assign bus.mem_waddr   = stage_q.waddr;
    assign bus.mem_wr_en   = stage_q.wr_en;
    assign bus.mem_hi      = stage_q.hi;
    assign bus.mem_lo      = stage_q.lo;
    assign bus.mem_whilo   = stage_q.whilo;
    assign bus.hilo_temp_o = hilo_temp_q;
    assign bus.cnt_o       = cnt_q;
    assign bubble_cnt      = bubble_q;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model of the stage rules.
module tb_ex_mem;
    import ex_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_ex, stall_mem, flush;
    logic [15:0] bubble_cnt;

    ex_mem_if bus ();

    ex_mem #(.BUB_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_ex   (stall_ex),
        .stall_mem  (stall_mem),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Controller contract: MEM never stalls while EX runs.
    always @(posedge clk) begin
        if (!rst) assert (!(stall_mem && !stall_ex)) else $error("illegal stall combination");
    end

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wr_en;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [15:0] bub;
    } out_t;

    typedef struct packed {
        logic        s_ex;
        logic        s_mem;
        logic        fl;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wr_en;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        out_t        exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: last MEM payload and an unbounded bubble tally.
    out_t m;
    int   bub_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_out(input string tag, input out_t e);
        chk({tag, ".wdata"}, 64'(bus.mem_wdata), 64'(e.wdata));
        chk({tag, ".waddr"}, 64'(bus.mem_waddr), 64'(e.waddr));
        chk({tag, ".wr_en"}, 64'(bus.mem_wr_en), 64'(e.wr_en));
        chk({tag, ".hi"},    64'(bus.mem_hi),    64'(e.hi));
        chk({tag, ".lo"},    64'(bus.mem_lo),    64'(e.lo));
        chk({tag, ".whilo"}, 64'(bus.mem_whilo), 64'(e.whilo));
        chk({tag, ".hilo"},  bus.hilo_temp_o,    e.hilo);
        chk({tag, ".cnt"},   64'(bus.cnt_o),     64'(e.cnt));
        chk({tag, ".bub"},   64'(bubble_cnt),    64'(e.bub));
    endtask

    task automatic drive(input vec_t v);
        stall_ex        = v.s_ex;
        stall_mem       = v.s_mem;
        flush           = v.fl;
        bus.ex_wdata    = v.wdata;
        bus.ex_waddr    = v.waddr;
        bus.ex_wr_en    = v.wr_en;
        bus.ex_hi       = v.hi;
        bus.ex_lo       = v.lo;
        bus.ex_whilo    = v.whilo;
        bus.hilo_temp_i = v.hilo;
        bus.cnt_i       = v.cnt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        bus.ex_wdata    = $urandom;
        bus.ex_waddr    = 5'($urandom);
        bus.ex_wr_en    = 1'($urandom);
        bus.ex_hi       = $urandom;
        bus.ex_lo       = $urandom;
        bus.ex_whilo    = 1'($urandom);
        bus.hilo_temp_i = {$urandom, $urandom};
        bus.cnt_i       = 2'($urandom);
    endtask

    // Reference rule set, evaluated with the inputs present at the edge.
    task automatic model_edge();
        out_t bubble;
        bubble = '0;
        if (rst) begin
            m = '0;
            bub_n = 0;
        end else if (flush) begin
            m = bubble;
            bub_n++;
        end else if (stall_mem) begin
            // hold: nothing moves
        end else if (stall_ex) begin
            m = bubble;
            m.hilo = bus.hilo_temp_i;
            m.cnt  = bus.cnt_i;
            bub_n++;
        end else begin
            m = '{bus.ex_wdata, bus.ex_waddr, bus.ex_wr_en, bus.ex_hi, bus.ex_lo,
                  bus.ex_whilo, 64'h0, 2'b00, 16'h0};
        end
        m.bub = (bub_n > 65535) ? 16'hFFFF : 16'(bub_n);
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0,1'b0,1'b0, 32'hDEADBEEF, 5'd3, 1'b1, 32'h11, 32'h22, 1'b1, 64'hABCD, 2'd2,
                    '{32'hDEADBEEF, 5'd3, 1'b1, 32'h11, 32'h22, 1'b1, 64'h0, 2'd0, 16'd0}};
        tbl[1]  = '{1'b1,1'b0,1'b0, 32'hAAAAAAAA, 5'd9, 1'b1, 32'h33, 32'h44, 1'b1, 64'h0000_0001_FFFF_0000, 2'd1,
                    '{32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_FFFF_0000, 2'd1, 16'd1}};
        tbl[2]  = '{1'b0,1'b0,1'b0, 32'h12345678, 5'd7, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
                    '{32'h12345678, 5'd7, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 16'd1}};
        for (int i = 3; i <= 5; i++)
            tbl[i] = '{1'b1,1'b1,1'b0, 32'h55555555, 5'd4, 1'b0, 32'h66, 32'h77, 1'b1, 64'h99, 2'd3,
                       '{32'h12345678, 5'd7, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 16'd1}};
        tbl[6]  = '{1'b1,1'b1,1'b1, 32'h0BADF00D, 5'd8, 1'b1, 32'h1, 32'h2, 1'b1, 64'h5, 2'd2,
                    '{32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 16'd2}};
        tbl[7]  = '{1'b0,1'b0,1'b0, 32'hFFFFFFFF, 5'd31, 1'b1, 32'hCAFE, 32'hF00D, 1'b1, 64'h0, 2'd0,
                    '{32'hFFFFFFFF, 5'd31, 1'b1, 32'hCAFE, 32'hF00D, 1'b1, 64'h0, 2'd0, 16'd2}};
        tbl[8]  = '{1'b1,1'b0,1'b0, 32'h1, 5'd2, 1'b1, 32'h3, 32'h4, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'd3,
                    '{32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 2'd3, 16'd3}};
        tbl[9]  = '{1'b1,1'b1,1'b0, 32'h7, 5'd7, 1'b1, 32'h7, 32'h7, 1'b0, 64'h77, 2'd0,
                    '{32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 2'd3, 16'd3}};
        tbl[10] = '{1'b0,1'b0,1'b1, 32'h1, 5'd1, 1'b1, 32'h1, 32'h1, 1'b1, 64'h1, 2'd1,
                    '{32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 16'd4}};
        tbl[11] = '{1'b0,1'b0,1'b0, 32'h42, 5'd1, 1'b0, 32'h0, 32'h0, 1'b0, 64'hFF, 2'd1,
                    '{32'h42, 5'd1, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, 16'd4}};

        // Reset with garbage on every input, including stalls and flush.
        rst = 1'b1; stall_ex = 1'b1; stall_mem = 1'b1; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step();
            chk_out($sformatf("reset%0d", i), '0);
        end
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Reset arriving mid EX-stall wipes the accumulator loop.
        stall_ex = 1'b1; stall_mem = 1'b0; flush = 1'b0;
        bus.hilo_temp_i = 64'hFEED_FACE_0BAD_CAFE; bus.cnt_i = 2'd2;
        step();
        chk("midstall.hilo", bus.hilo_temp_o, 64'hFEED_FACE_0BAD_CAFE);
        rst = 1'b1;
        step();
        chk("rst_midstall.hilo", bus.hilo_temp_o, 64'h0);
        chk("rst_midstall.cnt",  64'(bus.cnt_o), 64'h0);
        chk("rst_midstall.bub",  64'(bubble_cnt), 64'h0);
        step();
        rst = 1'b0;

        // Randomized legal traffic with occasional resets.
        m = '0; bub_n = 0;
        for (int i = 0; i < 3000; i++) begin
            int sc;
            rand_data();
            sc        = $urandom_range(0, 2);
            stall_ex  = (sc != 0);
            stall_mem = (sc == 2);
            flush     = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            model_edge();
            #1;
            chk_out("rnd", m);
        end

        // Saturation: 2^16+5 bubbles from a clean reset.
        rst = 1'b1; step(); rst = 1'b0;
        stall_ex = 1'b1; stall_mem = 1'b0; flush = 1'b0;
        for (int i = 1; i <= 65541; i++) begin
            step();
            if (i == 65534) chk("sat_fffe", 64'(bubble_cnt), 64'hFFFE);
            if (i == 65535) chk("sat_ffff", 64'(bubble_cnt), 64'hFFFF);
            if (i == 65537) chk("sat_nowrap", 64'(bubble_cnt), 64'hFFFF);
        end
        chk("sat_final", 64'(bubble_cnt), 64'hFFFF);
        flush = 1'b1;
        step();
        chk("sat_flush", 64'(bubble_cnt), 64'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS32 core.
- Captures the EX results each cycle: GPR write data/address/enable, HI/LO write.
- Carries multi-cycle MADD/MSUB accumulator state (hilo_temp, cnt) back to EX during an EX stall.
- Honours stall and flush from the pipeline controller and exports a saturating bubble counter for debug.

Parameters:
- DATA_W, 32, GPR/HI/LO data width.
- REG_ADDR_W, 5, GPR address width.
- CNT_W, 2, multi-cycle op step counter width.
- BUB_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall_ex  in  1  EX stage stalled this cycle.
- stall_mem  in  1  MEM stage stalled this cycle.
- flush  in  1  exception/flush; squash the MEM-side contents.
- ex_wdata  in  DATA_W  GPR write data from EX.
- ex_waddr  in  REG_ADDR_W  GPR write address from EX.
- ex_wr_en  in  1  GPR write enable from EX.
- ex_hi  in  DATA_W  HI write value.
- ex_lo  in  DATA_W  LO write value.
- ex_whilo  in  1  HI/LO write enable.
- hilo_temp_i  in  2*DATA_W  partial MADD/MSUB product from EX.
- cnt_i  in  CNT_W  multi-cycle step index from EX.
- mem_wdata  out  DATA_W  registered to MEM.
- mem_waddr  out  REG_ADDR_W  registered to MEM.
- mem_wr_en  out  1  registered to MEM.
- mem_hi  out  DATA_W  registered to MEM.
- mem_lo  out  DATA_W  registered to MEM.
- mem_whilo  out  1  registered to MEM.
- hilo_temp_o  out  2*DATA_W  accumulator state fed back to EX.
- cnt_o  out  CNT_W  step index fed back to EX.
- bubble_cnt  out  BUB_W  saturating count of bubbles inserted.

Behaviour:
- All state updates on the rising clk edge.
- Priority order: rst > flush > stall_mem > stall_ex > normal.
- rst=1:
  - All data outputs, hilo_temp_o, cnt_o and bubble_cnt = 0.
  - mem_waddr = 0 (NOP register address); mem_wr_en = 0; mem_whilo = 0.
- flush=1:
  - MEM outputs become a bubble: wdata/hi/lo = 0, waddr = 0, wr_en = 0, whilo = 0.
  - hilo_temp_o = 0, cnt_o = 0.
  - bubble_cnt += 1.
- stall_mem=1 (hold): every output holds its value, including hilo_temp_o and cnt_o; bubble_cnt unchanged.
- stall_ex=1 and stall_mem=0 (bubble):
  - MEM outputs are a bubble, as for flush.
  - hilo_temp_o <= hilo_temp_i and cnt_o <= cnt_i, so EX sees its partial product on the next cycle.
  - bubble_cnt += 1.
- Normal (no stall, no flush):
  - All mem_* outputs <= corresponding ex_* inputs; latency is exactly 1 cycle.
  - hilo_temp_o = 0, cnt_o = 0.
- stall_mem=1 with stall_ex=0 is illegal (the controller keeps stalls monotone); the block holds, and the bench asserts on it.
- bubble_cnt saturates at all-ones and does not wrap.
- Reset mid-stall: the next cycle shows reset values, with no residual hilo_temp.

Decomposition:
- Shared defines file: ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RstEnable, RegBus/RegAddrBus/DoubleRegBus widths.
- The stall-encoding constants also go in the shared defines file, for reuse by id_ex and mem_wb.
- No sub-module: a single always block with the prioritised update, plus the counter.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, mem_wr_en=0, bubble_cnt=0.
2. Pass-through: ex_wdata=0xDEADBEEF, ex_waddr=5'd3, ex_wr_en=1, no stall -> mem_* equal these values one cycle later.
3. EX-stall feedback: stall_ex=1, stall_mem=0, hilo_temp_i=0x0000_0001_FFFF_0000, cnt_i=1 -> next cycle:
   - hilo_temp_o=0x0000_0001_FFFF_0000, cnt_o=1.
   - mem_wr_en=0, mem_waddr=0, bubble_cnt=1.
4. Full stall: load 0x12345678 then stall_ex=stall_mem=1 for 3 cycles -> mem_wdata stays 0x12345678 and bubble_cnt stays unchanged.
5. Flush priority: flush=1, stall_mem=1, ex_wr_en=1 -> next cycle mem_wr_en=0, mem_whilo=0, cnt_o=0.
6. Saturation: force 2^16+5 bubbles -> bubble_cnt=0xFFFF, with no wrap.
